// File: rtl/bf_fetch_controller.sv
// Instruction fetch/sequencing front end for the brainfuck processor.
// Walks a registered program ROM, resolves loops locally and issues data/IO opcodes.
module bf_fetch_controller #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    output logic [ADDR_WIDTH-1:0] romAddr,
    input  logic [7:0]            romData,
    output logic [7:0]            instrOut,
    output logic                  instrValid,
    input  logic                  instrReady,
    input  logic                  cellZero,
    output logic                  halted,
    output logic                  error
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [7:0] OP_END   = 8'h00;
    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_LOOP  = 8'h5B;
    localparam logic [7:0] OP_BACK  = 8'h5D;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_SKIP_FETCH,
        S_SKIP_DECODE,
        S_HALT
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [7:0]            r_instr, w_instr_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_halted, w_halted_nxt;
    logic                  r_error, w_error_nxt;
    logic [SP_W-1:0]       r_sp, w_sp_nxt;
    logic [SP_W-1:0]       r_depth, w_depth_nxt;
    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic                  w_push;

    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [ADDR_WIDTH-1:0] w_top;
    logic                  w_pc_last;
    logic                  w_stack_full;
    logic                  w_stack_empty;

    assign w_pc_inc      = r_pc + ADDR_WIDTH'(1);
    assign w_pc_last     = &r_pc;
    assign w_top         = r_stack[IDX_W'(r_sp - SP_W'(1))];
    assign w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));
    assign w_stack_empty = (r_sp == SP_W'(0));

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_instr  <= 8'h00;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_error  <= 1'b0;
            r_sp     <= '0;
            r_depth  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_valid  <= w_valid_nxt;
            r_halted <= w_halted_nxt;
            r_error  <= w_error_nxt;
            r_sp     <= w_sp_nxt;
            r_depth  <= w_depth_nxt;
        end
    end

    // Return-address storage; entries above the stack pointer are don't-care
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[IDX_W'(r_sp)] <= r_pc;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_valid_nxt  = r_valid;
        w_halted_nxt = r_halted;
        w_error_nxt  = r_error;
        w_sp_nxt     = r_sp;
        w_depth_nxt  = r_depth;
        w_push       = 1'b0;

        case (r_state)
            S_FETCH: w_state_nxt = S_DECODE;

            S_DECODE: begin
                case (romData)
                    OP_END: w_state_nxt = S_HALT;
                    OP_INC, OP_DEC, OP_LEFT, OP_RIGHT, OP_OUT, OP_IN: begin
                        w_instr_nxt = romData;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                    OP_LOOP: begin
                        if (!cellZero) begin
                            if (w_stack_full) begin
                                w_error_nxt = 1'b1;
                                w_state_nxt = S_HALT;
                            end else if (w_pc_last) begin
                                w_state_nxt = S_HALT;
                            end else begin
                                w_push      = 1'b1;
                                w_sp_nxt    = r_sp + SP_W'(1);
                                w_pc_nxt    = w_pc_inc;
                                w_state_nxt = S_FETCH;
                            end
                        end else if (w_pc_last) begin
                            w_error_nxt = 1'b1;
                            w_state_nxt = S_HALT;
                        end else begin
                            w_depth_nxt = SP_W'(1);
                            w_pc_nxt    = w_pc_inc;
                            w_state_nxt = S_SKIP_FETCH;
                        end
                    end
                    OP_BACK: begin
                        if (w_stack_empty) begin
                            w_error_nxt = 1'b1;
                            w_state_nxt = S_HALT;
                        end else if (!cellZero) begin
                            // Resume at the first byte after the matching '['
                            w_pc_nxt    = w_top + ADDR_WIDTH'(1);
                            w_state_nxt = S_FETCH;
                        end else begin
                            w_sp_nxt = r_sp - SP_W'(1);
                            if (w_pc_last) begin
                                w_state_nxt = S_HALT;
                            end else begin
                                w_pc_nxt    = w_pc_inc;
                                w_state_nxt = S_FETCH;
                            end
                        end
                    end
                    default: begin
                        if (w_pc_last) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_pc_nxt    = w_pc_inc;
                            w_state_nxt = S_FETCH;
                        end
                    end
                endcase
            end

            S_ISSUE: begin
                if (instrReady) begin
                    w_valid_nxt = 1'b0;
                    if (w_pc_last) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_SKIP_FETCH: w_state_nxt = S_SKIP_DECODE;

            S_SKIP_DECODE: begin
                if (romData == OP_END ||
                    (romData == OP_LOOP && r_depth == SP_W'(STACK_DEPTH)) ||
                    w_pc_last) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_SKIP_FETCH;
                    if (romData == OP_LOOP) begin
                        w_depth_nxt = r_depth + SP_W'(1);
                    end else if (romData == OP_BACK) begin
                        w_depth_nxt = r_depth - SP_W'(1);
                        if (r_depth == SP_W'(1)) begin
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
            end

            S_HALT: w_state_nxt = S_HALT;

            default: w_state_nxt = S_HALT;
        endcase

        if (w_state_nxt == S_HALT) begin
            w_halted_nxt = 1'b1;
            w_valid_nxt  = 1'b0;
        end
    end

    assign romAddr    = r_pc;
    assign instrOut   = r_instr;
    assign instrValid = r_valid;
    assign halted     = r_halted;
    assign error      = r_error;

endmodule

// File: tb/tb_bf_fetch_controller.sv
// Directed bench for bf_fetch_controller: loops, skips, backpressure, faults, halt and reset.
module tb_bf_fetch_controller;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic [AW-1:0] romAddr;
    logic [7:0]    romData = 8'h00;
    logic [7:0]    instrOut;
    logic          instrValid;
    logic          instrReady = 1'b1;
    logic          cellZero = 1'b0;
    logic          halted;
    logic          error;

    logic [7:0]    rom [16];
    int            vectors = 0;
    int            errors = 0;
    int            acc_cnt = 0;

    bf_fetch_controller #(.ADDR_WIDTH(AW), .STACK_DEPTH(8)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .romAddr    (romAddr),
        .romData    (romData),
        .instrOut   (instrOut),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .cellZero   (cellZero),
        .halted     (halted),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Registered program ROM with one cycle of read latency
    always @(posedge clk) romData <= rom[romAddr];

    always @(posedge clk) begin
        if (!resetN) acc_cnt <= 0;
        else if (instrValid && instrReady) acc_cnt <= acc_cnt + 1;
    end

    task automatic load_rom(input string s);
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len() && i < 16; i++) rom[i] = s[i];
    endtask

    // Leaves the bench at the falling edge of cycle 0 (first FETCH)
    task automatic do_reset;
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_issue(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (instrValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        load_rom("+[.+]>");
        cellZero = 1'b0; instrReady = 1'b1;
        do_reset();
        vectors++; if (romAddr !== 4'd0) begin errors++; $display("FAIL reset_addr got %h want 0", romAddr); end
        vectors++; if (instrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instrValid); end
        vectors++; if (instrOut !== 8'h00) begin errors++; $display("FAIL reset_instr got %h want 00", instrOut); end
        vectors++; if (halted !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_flags got h=%b e=%b want 0 0", halted, error); end
    endtask

    task automatic test_loop;
        bit ok;
        load_rom("+[.+]>");
        cellZero = 1'b0; instrReady = 1'b1;
        do_reset();
        step(2);
        vectors++; if (instrValid !== 1'b1 || instrOut !== 8'h2B || romAddr !== 4'd0) begin errors++; $display("FAIL loop_first got v=%b op=%h a=%h want 1 2b 0", instrValid, instrOut, romAddr); end
        wait_issue(10, ok);
        vectors++; if (!ok || instrOut !== 8'h2E || romAddr !== 4'd2) begin errors++; $display("FAIL loop_dot got ok=%b op=%h a=%h want 1 2e 2", ok, instrOut, romAddr); end
        wait_issue(10, ok);
        vectors++; if (!ok || instrOut !== 8'h2B || romAddr !== 4'd3) begin errors++; $display("FAIL loop_plus got ok=%b op=%h a=%h want 1 2b 3", ok, instrOut, romAddr); end
        step(1);
        vectors++; if (romAddr !== 4'd4) begin errors++; $display("FAIL loop_fetch_back got %h want 4", romAddr); end
        step(2);
        vectors++; if (romAddr !== 4'd2) begin errors++; $display("FAIL loop_return got %h want 2", romAddr); end
        cellZero = 1'b1;
        wait_issue(10, ok);
        vectors++; if (!ok || instrOut !== 8'h2E || romAddr !== 4'd2) begin errors++; $display("FAIL loop_iter2 got ok=%b op=%h a=%h want 1 2e 2", ok, instrOut, romAddr); end
        wait_issue(10, ok);
        wait_issue(10, ok);
        vectors++; if (!ok || instrOut !== 8'h3E || romAddr !== 4'd5) begin errors++; $display("FAIL loop_exit got ok=%b op=%h a=%h want 1 3e 5", ok, instrOut, romAddr); end
        step(3);
        vectors++; if (halted !== 1'b1 || error !== 1'b0 || romAddr !== 4'd6) begin errors++; $display("FAIL loop_halt got h=%b e=%b a=%h want 1 0 6", halted, error, romAddr); end
    endtask

    task automatic test_skip;
        bit ok;
        load_rom("+[.+]>");
        cellZero = 1'b1; instrReady = 1'b1;
        do_reset();
        wait_issue(10, ok);
        vectors++; if (!ok || instrOut !== 8'h2B || romAddr !== 4'd0) begin errors++; $display("FAIL skip_first got ok=%b op=%h a=%h want 1 2b 0", ok, instrOut, romAddr); end
        wait_issue(30, ok);
        vectors++; if (!ok || instrOut !== 8'h3E || romAddr !== 4'd5 || acc_cnt !== 1) begin errors++; $display("FAIL skip_next got ok=%b op=%h a=%h acc=%0d want 1 3e 5 1", ok, instrOut, romAddr, acc_cnt); end
        load_rom("[[-]]+");
        do_reset();
        wait_issue(30, ok);
        vectors++; if (!ok || instrOut !== 8'h2B || romAddr !== 4'd5 || acc_cnt !== 0) begin errors++; $display("FAIL skip_nested got ok=%b op=%h a=%h acc=%0d want 1 2b 5 0", ok, instrOut, romAddr, acc_cnt); end
        load_rom("x-");
        cellZero = 1'b0;
        do_reset();
        step(4);
        vectors++; if (instrValid !== 1'b1 || instrOut !== 8'h2D || romAddr !== 4'd1) begin errors++; $display("FAIL comment got v=%b op=%h a=%h want 1 2d 1", instrValid, instrOut, romAddr); end
    endtask

    task automatic test_backpressure;
        bit ok;
        load_rom(",+");
        cellZero = 1'b0; instrReady = 1'b0;
        do_reset();
        step(2);
        for (int i = 0; i < 5; i++) begin
            vectors++; if (instrValid !== 1'b1 || instrOut !== 8'h2C || romAddr !== 4'd0) begin errors++; $display("FAIL bp_hold%0d got v=%b op=%h a=%h want 1 2c 0", i, instrValid, instrOut, romAddr); end
            step(1);
        end
        vectors++; if (instrValid !== 1'b1 || acc_cnt !== 0) begin errors++; $display("FAIL bp_pre got v=%b acc=%0d want 1 0", instrValid, acc_cnt); end
        instrReady = 1'b1;
        step(1);
        vectors++; if (instrValid !== 1'b0 || romAddr !== 4'd1 || acc_cnt !== 1) begin errors++; $display("FAIL bp_accept got v=%b a=%h acc=%0d want 0 1 1", instrValid, romAddr, acc_cnt); end
        wait_issue(10, ok);
        vectors++; if (!ok || instrOut !== 8'h2B || romAddr !== 4'd1) begin errors++; $display("FAIL bp_next got ok=%b op=%h a=%h want 1 2b 1", ok, instrOut, romAddr); end
    endtask

    task automatic test_errors;
        load_rom("]");
        cellZero = 1'b0; instrReady = 1'b1;
        do_reset();
        step(1);
        vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL unmatched_early got h=%b want 0", halted); end
        step(1);
        vectors++; if (halted !== 1'b1 || error !== 1'b1 || instrValid !== 1'b0) begin errors++; $display("FAIL unmatched got h=%b e=%b v=%b want 1 1 0", halted, error, instrValid); end
        step(3);
        vectors++; if (halted !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL unmatched_sticky got h=%b e=%b want 1 1", halted, error); end

        load_rom("[[[[[[[[[");
        do_reset();
        step(17);
        vectors++; if (halted !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL overflow_early got h=%b e=%b want 0 0", halted, error); end
        step(1);
        vectors++; if (halted !== 1'b1 || error !== 1'b1 || romAddr !== 4'd8) begin errors++; $display("FAIL overflow got h=%b e=%b a=%h want 1 1 8", halted, error, romAddr); end

        load_rom("[+");
        cellZero = 1'b1;
        do_reset();
        step(5);
        vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL skip_end_early got h=%b want 0", halted); end
        step(1);
        vectors++; if (halted !== 1'b1 || error !== 1'b1 || acc_cnt !== 0) begin errors++; $display("FAIL skip_end got h=%b e=%b acc=%0d want 1 1 0", halted, error, acc_cnt); end
    endtask

    task automatic test_halt;
        bit ok;
        load_rom("+");
        cellZero = 1'b0; instrReady = 1'b1;
        do_reset();
        step(5);
        vectors++; if (halted !== 1'b1 || error !== 1'b0 || romAddr !== 4'd1) begin errors++; $display("FAIL halt_zero got h=%b e=%b a=%h want 1 0 1", halted, error, romAddr); end
        step(4);
        vectors++; if (halted !== 1'b1 || romAddr !== 4'd1 || instrValid !== 1'b0) begin errors++; $display("FAIL halt_frozen got h=%b a=%h v=%b want 1 1 0", halted, romAddr, instrValid); end

        load_rom("++++++++++++++++");
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (halted === 1'b1) begin ok = 1'b1; break; end
        end
        vectors++; if (!ok || acc_cnt !== 16 || error !== 1'b0 || romAddr !== 4'd15) begin errors++; $display("FAIL end_of_space got ok=%b acc=%0d e=%b a=%h want 1 16 0 f", ok, acc_cnt, error, romAddr); end
    endtask

    task automatic test_reset_mid_issue;
        bit ok;
        load_rom("+>");
        cellZero = 1'b0; instrReady = 1'b0;
        do_reset();
        step(2);
        vectors++; if (instrValid !== 1'b1) begin errors++; $display("FAIL mid_pending got v=%b want 1", instrValid); end
        resetN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        vectors++; if (instrValid !== 1'b0 || romAddr !== 4'd0 || halted !== 1'b0 || acc_cnt !== 0) begin errors++; $display("FAIL mid_reset got v=%b a=%h h=%b acc=%0d want 0 0 0 0", instrValid, romAddr, halted, acc_cnt); end
        instrReady = 1'b1;
        step(2);
        vectors++; if (instrValid !== 1'b1 || instrOut !== 8'h2B || romAddr !== 4'd0) begin errors++; $display("FAIL mid_restart got v=%b op=%h a=%h want 1 2b 0", instrValid, instrOut, romAddr); end
        wait_issue(10, ok);
        vectors++; if (!ok || instrOut !== 8'h3E || romAddr !== 4'd1) begin errors++; $display("FAIL mid_second got ok=%b op=%h a=%h want 1 3e 1", ok, instrOut, romAddr); end
    endtask

    initial begin
        test_reset();
        test_loop();
        test_skip();
        test_backpressure();
        test_errors();
        test_halt();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bf_fetch_controller.md
Name: bf_fetch_controller

Overview:
- Sequences a registered program ROM (1-cycle read latency, 8-bit brainfuck opcodes) for the brainfuck processor.
- Owns the program counter and fetches instructions.
- Resolves loops ('[' / ']') internally using a return-address stack and a forward-skip scanner.
- Issues data/IO opcodes ('+', '-', '<', '>', '.', ',') to the execute unit over a valid/ready handshake.

Parameters:
ADDR_WIDTH, 4, ROM address width; program length is at most 2^ADDR_WIDTH bytes
STACK_DEPTH, 8, maximum loop nesting depth held in the return-address stack

Ports:
clk  input  1  system clock; all state updates on its rising edge
resetN  input  1  reset, synchronous, active-low
romAddr  output  ADDR_WIDTH  registered ROM address (equals PC); ROM samples it on the next rising edge
romData  input  8  ROM data; valid the cycle after romAddr is presented
instrOut  output  8  opcode issued to the execute unit
instrValid  output  1  instrOut is valid; held until accepted
instrReady  input  1  execute unit accepts instrOut this cycle when instrValid=1
cellZero  input  1  1 when the current data cell is zero; sampled only in DECODE on a bracket
halted  output  1  program finished (0x00, end of address space, or error); sticky until reset
error  output  1  fault (unmatched bracket, stack overflow); sticky until reset

Behaviour:
- Reset (resetN=0 at clk edge): pc=0, romAddr=0, instrOut=0x00, instrValid=0, halted=0, error=0, stack empty, skip depth=0, state=FETCH. Reset overrides any state, including a pending ISSUE.
- States: FETCH, DECODE, ISSUE, SKIP_FETCH, SKIP_DECODE, HALT.
- FETCH: romAddr=pc; go to DECODE. Exactly one cycle.
- DECODE, by romData:
  - 0x00: go to HALT.
  - One of 0x2B, 0x2D, 0x3C, 0x3E, 0x2E, 0x2C: latch into instrOut, set instrValid=1, go to ISSUE.
  - 0x5B '[' with cellZero=0: if stack full, set error and go to HALT; else push pc, pc=pc+1, go to FETCH.
  - 0x5B '[' with cellZero=1: skip depth=1, pc=pc+1, go to SKIP_FETCH.
  - 0x5D ']' with stack empty: set error, go to HALT.
  - 0x5D ']' with cellZero=0: pc=top+1, stack unchanged, go to FETCH.
  - 0x5D ']' with cellZero=1: pop, pc=pc+1, go to FETCH.
  - Any other byte: comment; pc=pc+1, go to FETCH.
- ISSUE: hold instrValid and instrOut stable. On instrValid&&instrReady: instrValid=0, pc=pc+1, go to FETCH.
- Execute-unit contract: cellZero reflects all accepted instructions by the DECODE that follows. That DECODE is at least 2 cycles after acceptance.
- Brackets and comments are never issued on instrOut.
- SKIP_FETCH then SKIP_DECODE (2 cycles per byte):
  - '[': depth+1.
  - ']': depth-1; if the result is 0, pc=pc+1, go to FETCH.
  - Otherwise: pc=pc+1.
  - Stack is untouched during skip.
  - depth would exceed STACK_DEPTH: error, HALT.
  - 0x00 while depth>0: error, HALT.
- End of space: any pc increment from 2^ADDR_WIDTH-1 goes to HALT instead of wrapping. If this happens during skip, also set error.
- HALT: halted=1, instrValid=0, romAddr frozen at last value. Only reset leaves HALT.
- Stack: STACK_DEPTH entries of ADDR_WIDTH bits; push/pop/top are single-cycle. Push and pop never occur in the same cycle.
- Throughput: issued opcode takes 3 cycles minimum (FETCH, DECODE, ISSUE with instrReady=1). Bracket or comment takes 2 cycles.

Test Plan:
- ROM "+[.+]>": release reset, instrReady=1, cellZero=0. Required: romAddr=0 in cycle 0; instrValid=1 with instrOut=0x2B in cycle 2; next issue is 0x2E from address 2. After ']' at address 4, romAddr returns to 2.
- Same ROM with cellZero=1 at the '[' decode: '.' and '+' inside the loop are never issued. Next issued opcode is 0x3E from address 5. ROM "[[-]]+" with cellZero=1: first issued opcode is 0x2B from address 5.
- Backpressure: hold instrReady=0 for 5 cycles during ISSUE of 0x2C. Required: instrValid=1, instrOut=0x2C, romAddr unchanged throughout; single acceptance on the cycle instrReady rises; pc advances by exactly 1.
- Errors:
  - ROM "]": error=1 and halted=1 after the DECODE cycle.
  - STACK_DEPTH+1 consecutive '[' with cellZero=0: error on the 9th '['.
  - "[+" with cellZero=1 and no ']' before 0x00: error=1, halted=1.
- Halt and reset: ROM "+" then 0x00 gives halted=1 with romAddr held at 1. ROM of 16 '+' with no 0x00 gives halted=1 and error=0 after the 16th acceptance. resetN=0 for one edge mid-ISSUE: next cycle instrValid=0, romAddr=0, halted=0, then normal restart from address 0.
